lob_cmd_sequencer: RTL and testbench
====================================

# lob_cmd_sequencer

Command sequencer for the limit order book. It accepts parsed order commands (add, delete, volume-at-limit query) into a small queue and issues them one at a time to the AddOrder, DeleteOrder and GetVolumeAtLimit engines. Those engines share the book memory, so only one may run at a time. The block waits for the active engine's done, guards the wait with a timeout, and returns an in-order response to the message/display side.

## Interface
Parameters:
- ID_W, 16, order id width
- SIZE_W, 16, order size width
- PRICE_W, 16, limit price / volume width
- FIFO_DEPTH, 4, command queue entries (power of two, ≥2)
- TIMEOUT_CYC, 255, max WAIT cycles before abort (1..255)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  one clock; reset is asynchronous and active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  equals !fifo_full
- cmd_op  in  2  00 ADD, 01 DELETE, 10 VOLUME, 11 reserved
- cmd_side  in  1  0 bid, 1 ask
- cmd_id  in  ID_W  order id
- cmd_size  in  SIZE_W  order size
- cmd_limit  in  PRICE_W  limit price
- eng_side, eng_id, eng_size, eng_limit  out  1/ID_W/SIZE_W/PRICE_W  shared engine operand bus
- add_start, del_start, vol_start  out  1  one-cycle start pulses
- add_done, del_done, vol_done  in  1  engine done, level
- add_success, del_success  in  1  engine result flags
- vol_volume  in  PRICE_W  query result
- rsp_valid  out  1  response held until accepted
- rsp_ready  in  1  response consumer ready
- rsp_op  out  2  echo of the command op
- rsp_ok  out  1  success flag
- rsp_timeout  out  1  engine did not finish
- rsp_data  out  PRICE_W  volume for VOLUME, else 0
- busy  out  1  (state != IDLE) | !fifo_empty

## Operation
- Push occurs when cmd_valid & cmd_ready. Commands are never dropped and are serviced strictly FIFO.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if the FIFO is non-empty, pop the head into the op/operand registers. Op 11 goes directly to RESP with ok=0, data=0 and starts no engine. Any other op goes to ISSUE.
  - ISSUE: assert the selected engine's start for exactly one cycle. Clear the timeout counter. Go to WAIT.
  - WAIT: watch only the selected engine's done. When it is high, capture the result and go to RESP. Otherwise, if counter == TIMEOUT_CYC-1, set timeout=1, ok=0, data=0 and go to RESP. Otherwise increment the counter.
  - RESP: hold rsp_valid until rsp_ready is sampled high, then go to IDLE.
- Result mapping:
  - ADD: ok=add_success, data=0.
  - DELETE: ok=del_success, data=0.
  - VOLUME: ok=1, data=vol_volume.
- eng_* operands are driven from the op registers and stay stable from ISSUE through WAIT.
- Done signals from non-selected engines are ignored. Any done asserted during ISSUE is ignored (stale level from the prior run).

## Timing
- Reset values: all *_start=0, rsp_valid=0, rsp_ok=0, rsp_timeout=0, rsp_op=0, rsp_data=0, eng_*=0, busy=0, FIFO empty, state IDLE. cmd_ready=1 during and after reset.
- A command pushed at edge 0 leaves IDLE at edge 1. Its start is high between edges 1 and 2. WAIT begins at edge 2.
- If done is first sampled high at WAIT edge k, rsp_valid rises after edge k, i.e. one cycle of done-to-response latency.
- A timeout fires after exactly TIMEOUT_CYC WAIT cycles.
- If done and the timeout condition occur in the same cycle, done wins.
- FIFO: push and pop in the same cycle are allowed when non-empty. When full, cmd_ready=0 and no push occurs, even if a pop happens in the same cycle.
- Reset mid-operation: all state is lost immediately, pending starts are deasserted and queued commands are discarded. Engines share the same rst.
- The counter is 8-bit and never wraps, because it stops at TIMEOUT_CYC-1.

## Structure
- Shared package lob_pkg holds the op codes (OP_ADD, OP_DEL, OP_VOL, OP_RSVD), the FSM state encoding, and the default widths shared with the engines.
- One sub-module, lob_cmd_fifo: a parameterised synchronous FIFO with asynchronous active-high reset, a width of 2+1+ID_W+SIZE_W+PRICE_W bits, and full/empty flags derived from a count register.

## Test plan
- ADD side=0 id=1 size=1 limit=1; add_done high 3 cycles after start with add_success=1 → single add_start pulse, eng_id=1, eng_limit=1; response op=00 ok=1 timeout=0 data=0.
- VOLUME side=0 limit=1; vol_done with vol_volume=5 → vol_start only; response op=10 ok=1 data=5.
- Backpressure: engines stalled and rsp_ready=0; offer 6 commands back-to-back → 5 accepted (1 active plus 4 queued), then cmd_ready=0. Releasing the engines and rsp_ready yields 5 responses in push order.
- Timeout: TIMEOUT_CYC=16, DELETE with del_done held low → response after 16 WAIT cycles with ok=0 timeout=1. The next queued command then issues normally.
- Isolation: vol_done held high throughout an ADD → ignored, and the ADD completes only on add_done. Op 11 → response ok=0 data=0 with no start pulse.
- Reset asserted mid-WAIT with 2 commands queued → all outputs take their reset values immediately, cmd_ready=1, busy=0, and no responses are emitted after release.

Source files
------------

// File: rtl/lob_pkg.sv
// ============================================================
// lob_pkg : op codes, sequencer states and default LOB widths
// Revision: 1.0
// ============================================================
`default_nettype none

package lob_pkg;

  localparam int ID_W_DEF    = 16;
  localparam int SIZE_W_DEF  = 16;
  localparam int PRICE_W_DEF = 16;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_DEL  = 2'b01,
    OP_VOL  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/lob_cmd_fifo.sv
// ============================================================
// lob_cmd_fifo : synchronous command FIFO, flags from a count register
// Revision: 1.0
// ============================================================
`default_nettype none

module lob_cmd_fifo #(
  parameter int WIDTH = 51,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses pushes even when a pop frees a slot this cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/lob_cmd_sequencer.sv
// ============================================================
// lob_cmd_sequencer : queues LOB commands, runs one engine at a time
// Revision: 1.0
// ============================================================
`default_nettype none

module lob_cmd_sequencer
  import lob_pkg::*;
#(
  parameter int ID_W        = ID_W_DEF,
  parameter int SIZE_W      = SIZE_W_DEF,
  parameter int PRICE_W     = PRICE_W_DEF,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic               cmd_side,
  input  logic [ID_W-1:0]    cmd_id,
  input  logic [SIZE_W-1:0]  cmd_size,
  input  logic [PRICE_W-1:0] cmd_limit,
  output logic               eng_side,
  output logic [ID_W-1:0]    eng_id,
  output logic [SIZE_W-1:0]  eng_size,
  output logic [PRICE_W-1:0] eng_limit,
  output logic               add_start,
  output logic               del_start,
  output logic               vol_start,
  input  logic               add_done,
  input  logic               del_done,
  input  logic               vol_done,
  input  logic               add_success,
  input  logic               del_success,
  input  logic [PRICE_W-1:0] vol_volume,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [1:0]         rsp_op,
  output logic               rsp_ok,
  output logic               rsp_timeout,
  output logic [PRICE_W-1:0] rsp_data,
  output logic               busy
);

  localparam int CMD_W    = 2 + 1 + ID_W + SIZE_W + PRICE_W;
  localparam int SIZE_LSB = PRICE_W;
  localparam int ID_LSB   = PRICE_W + SIZE_W;
  localparam int SIDE_BIT = ID_LSB + ID_W;
  localparam int OP_LSB   = SIDE_BIT + 1;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  state_e             state;
  op_e                op_r;
  logic [7:0]         wait_cnt;
  logic               sel_done;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic [CMD_W-1:0]   fifo_wdata;
  logic [CMD_W-1:0]   head;
  op_e                head_op;

  assign fifo_wdata = {cmd_op, cmd_side, cmd_id, cmd_size, cmd_limit};
  assign fifo_pop   = (state == ST_IDLE) && !fifo_empty;
  assign head_op    = op_e'(head[OP_LSB +: 2]);
  assign cmd_ready  = !fifo_full;
  assign busy       = (state != ST_IDLE) || !fifo_empty;

  lob_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Only the engine owning the current command may end the wait.
  always_comb begin
    sel_done = 1'b0;
    case (op_r)
      OP_ADD:  sel_done = add_done;
      OP_DEL:  sel_done = del_done;
      OP_VOL:  sel_done = vol_done;
      default: sel_done = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      op_r        <= OP_ADD;
      eng_side    <= 1'b0;
      eng_id      <= '0;
      eng_size    <= '0;
      eng_limit   <= '0;
      add_start   <= 1'b0;
      del_start   <= 1'b0;
      vol_start   <= 1'b0;
      wait_cnt    <= '0;
      rsp_valid   <= 1'b0;
      rsp_op      <= 2'b00;
      rsp_ok      <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_data    <= '0;
    end else begin
      add_start <= 1'b0;
      del_start <= 1'b0;
      vol_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            op_r      <= head_op;
            eng_side  <= head[SIDE_BIT];
            eng_id    <= head[ID_LSB +: ID_W];
            eng_size  <= head[SIZE_LSB +: SIZE_W];
            eng_limit <= head[0 +: PRICE_W];
            if (head_op == OP_RSVD) begin
              rsp_valid   <= 1'b1;
              rsp_op      <= OP_RSVD;
              rsp_ok      <= 1'b0;
              rsp_timeout <= 1'b0;
              rsp_data    <= '0;
              state       <= ST_RESP;
            end else begin
              // Start is registered here so it is high for the ISSUE cycle.
              add_start <= (head_op == OP_ADD);
              del_start <= (head_op == OP_DEL);
              vol_start <= (head_op == OP_VOL);
              state     <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (sel_done) begin
            rsp_valid   <= 1'b1;
            rsp_op      <= op_r;
            rsp_timeout <= 1'b0;
            case (op_r)
              OP_ADD: begin
                rsp_ok   <= add_success;
                rsp_data <= '0;
              end
              OP_DEL: begin
                rsp_ok   <= del_success;
                rsp_data <= '0;
              end
              OP_VOL: begin
                rsp_ok   <= 1'b1;
                rsp_data <= vol_volume;
              end
              default: begin
                rsp_ok   <= 1'b0;
                rsp_data <= '0;
              end
            endcase
            state <= ST_RESP;
          end else if (wait_cnt == TO_LAST) begin
            rsp_valid   <= 1'b1;
            rsp_op      <= op_r;
            rsp_ok      <= 1'b0;
            rsp_timeout <= 1'b1;
            rsp_data    <= '0;
            state       <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lob_cmd_sequencer.sv
// ============================================================
// tb_lob_cmd_sequencer : directed self-checking bench for the sequencer
// Revision: 1.0
// ============================================================
`default_nettype none

module tb_lob_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic        cmd_side = 1'b0;
  logic [15:0] cmd_id = 16'd0;
  logic [15:0] cmd_size = 16'd0;
  logic [15:0] cmd_limit = 16'd0;
  logic        eng_side;
  logic [15:0] eng_id;
  logic [15:0] eng_size;
  logic [15:0] eng_limit;
  logic        add_start, del_start, vol_start;
  logic        add_done = 1'b0, del_done = 1'b0, vol_done = 1'b0;
  logic        add_success = 1'b0, del_success = 1'b0;
  logic [15:0] vol_volume = 16'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [1:0]  rsp_op;
  logic        rsp_ok;
  logic        rsp_timeout;
  logic [15:0] rsp_data;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int add_cnt = 0, del_cnt = 0, vol_cnt = 0;

  lob_cmd_sequencer #(
    .ID_W(16), .SIZE_W(16), .PRICE_W(16), .FIFO_DEPTH(4), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_side(cmd_side), .cmd_id(cmd_id), .cmd_size(cmd_size), .cmd_limit(cmd_limit),
    .eng_side(eng_side), .eng_id(eng_id), .eng_size(eng_size), .eng_limit(eng_limit),
    .add_start(add_start), .del_start(del_start), .vol_start(vol_start),
    .add_done(add_done), .del_done(del_done), .vol_done(vol_done),
    .add_success(add_success), .del_success(del_success), .vol_volume(vol_volume),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op), .rsp_ok(rsp_ok),
    .rsp_timeout(rsp_timeout), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (add_start) add_cnt++;
    if (del_start) del_cnt++;
    if (vol_start) vol_cnt++;
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_cmd(input logic [1:0] op, input logic [15:0] id, input logic [15:0] limit);
    cmd_valid = 1'b1; cmd_op = op; cmd_side = 1'b0;
    cmd_id = id; cmd_size = 16'd1; cmd_limit = limit;
    for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int max_cyc, output int n);
    n = 0;
    while (!rsp_valid && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic accept_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
    checks++; if ({busy, rsp_valid, add_start, del_start, vol_start} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000", {busy, rsp_valid, add_start, del_start, vol_start}); end
    checks++; if ({eng_side, eng_id, eng_size, eng_limit} !== 49'd0) begin
      errors++; $display("FAIL reset_eng: got %h want 0", {eng_side, eng_id, eng_size, eng_limit}); end
    checks++; if ({rsp_op, rsp_ok, rsp_timeout, rsp_data} !== 20'd0) begin
      errors++; $display("FAIL reset_rsp: got %h want 0", {rsp_op, rsp_ok, rsp_timeout, rsp_data}); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({cmd_ready, busy, rsp_valid} !== 3'b100) begin
      errors++; $display("FAIL reset_release: got %b want 100", {cmd_ready, busy, rsp_valid}); end
  endtask

  task automatic test_add();
    int a0, d0, v0;
    a0 = add_cnt; d0 = del_cnt; v0 = vol_cnt;
    push_cmd(2'b00, 16'd1, 16'd1);
    checks++; if ({add_start, busy} !== 2'b01) begin errors++; $display("FAIL add_pre: got %b want 01", {add_start, busy}); end
    @(negedge clk);
    checks++; if (add_start !== 1'b1) begin errors++; $display("FAIL add_start: got %b want 1", add_start); end
    checks++; if ({eng_side, eng_id, eng_size, eng_limit} !== {1'b0, 16'd1, 16'd1, 16'd1}) begin
      errors++; $display("FAIL add_eng: got %h want 0000100010001", {eng_side, eng_id, eng_size, eng_limit}); end
    @(negedge clk);
    checks++; if (add_start !== 1'b0) begin errors++; $display("FAIL add_pulse_width: got %b want 0", add_start); end
    @(negedge clk);
    add_done = 1'b1; add_success = 1'b1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_early_rsp: got %b want 0", rsp_valid); end
    @(negedge clk);
    checks++; if ({rsp_valid, rsp_op, rsp_ok, rsp_timeout, rsp_data} !== {1'b1, 2'b00, 1'b1, 1'b0, 16'd0}) begin
      errors++; $display("FAIL add_rsp: got %h want %h", {rsp_valid, rsp_op, rsp_ok, rsp_timeout, rsp_data}, {1'b1, 2'b00, 1'b1, 1'b0, 16'd0}); end
    checks++; if ({add_cnt - a0, del_cnt - d0, vol_cnt - v0} !== {32'd1, 32'd0, 32'd0}) begin
      errors++; $display("FAIL add_pulses: got %0d/%0d/%0d want 1/0/0", add_cnt - a0, del_cnt - d0, vol_cnt - v0); end
    accept_rsp();
    add_done = 1'b0; add_success = 1'b0;
    checks++; if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL add_accept: got %b want 00", {rsp_valid, busy}); end
  endtask

  task automatic test_volume();
    int n, a0, d0, v0;
    a0 = add_cnt; d0 = del_cnt; v0 = vol_cnt;
    vol_volume = 16'd5;
    push_cmd(2'b10, 16'd0, 16'd1);
    for (int i = 0; i < 10 && !vol_start; i++) @(negedge clk);
    checks++; if (vol_start !== 1'b1) begin errors++; $display("FAIL vol_start: got %b want 1", vol_start); end
    vol_done = 1'b1;
    wait_rsp(20, n);
    checks++; if (n != 2) begin errors++; $display("FAIL vol_latency: got %0d want 2", n); end
    checks++; if ({rsp_valid, rsp_op, rsp_ok, rsp_timeout, rsp_data} !== {1'b1, 2'b10, 1'b1, 1'b0, 16'd5}) begin
      errors++; $display("FAIL vol_rsp: got %h want %h", {rsp_valid, rsp_op, rsp_ok, rsp_timeout, rsp_data}, {1'b1, 2'b10, 1'b1, 1'b0, 16'd5}); end
    checks++; if ({add_cnt - a0, del_cnt - d0, vol_cnt - v0} !== {32'd0, 32'd0, 32'd1}) begin
      errors++; $display("FAIL vol_pulses: got %0d/%0d/%0d want 0/0/1", add_cnt - a0, del_cnt - d0, vol_cnt - v0); end
    accept_rsp();
    vol_done = 1'b0;
  endtask

  task automatic test_timeout();
    int n;
    push_cmd(2'b01, 16'd5, 16'd2);
    push_cmd(2'b00, 16'd6, 16'd3);
    for (int i = 0; i < 10 && !del_start; i++) @(negedge clk);
    checks++; if (del_start !== 1'b1) begin errors++; $display("FAIL to_start: got %b want 1", del_start); end
    wait_rsp(40, n);
    checks++; if (n != 17) begin errors++; $display("FAIL to_cycles: got %0d want 17", n); end
    checks++; if ({rsp_valid, rsp_op, rsp_ok, rsp_timeout, rsp_data} !== {1'b1, 2'b01, 1'b0, 1'b1, 16'd0}) begin
      errors++; $display("FAIL to_rsp: got %h want %h", {rsp_valid, rsp_op, rsp_ok, rsp_timeout, rsp_data}, {1'b1, 2'b01, 1'b0, 1'b1, 16'd0}); end
    accept_rsp();
    for (int i = 0; i < 10 && !add_start; i++) @(negedge clk);
    checks++; if ({add_start, eng_id} !== {1'b1, 16'd6}) begin
      errors++; $display("FAIL to_next_issue: got %h want 10006", {add_start, eng_id}); end
    add_done = 1'b1; add_success = 1'b0;
    wait_rsp(10, n);
    checks++; if ({rsp_valid, rsp_op, rsp_ok, rsp_timeout} !== {1'b1, 2'b00, 1'b0, 1'b0}) begin
      errors++; $display("FAIL to_next_rsp: got %b want 1000", {rsp_valid, rsp_op, rsp_ok, rsp_timeout}); end
    accept_rsp();
    add_done = 1'b0;
    // done arriving on the final WAIT cycle must beat the timeout
    push_cmd(2'b01, 16'd7, 16'd4);
    for (int i = 0; i < 10 && !del_start; i++) @(negedge clk);
    del_success = 1'b1;
    repeat (16) @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL race_early: got %b want 0", rsp_valid); end
    del_done = 1'b1;
    @(negedge clk);
    checks++; if ({rsp_valid, rsp_ok, rsp_timeout} !== 3'b110) begin
      errors++; $display("FAIL race_done_wins: got %b want 110", {rsp_valid, rsp_ok, rsp_timeout}); end
    accept_rsp();
    del_done = 1'b0; del_success = 1'b0;
  endtask

  task automatic test_isolation();
    int n, a0, d0, v0;
    a0 = add_cnt; d0 = del_cnt; v0 = vol_cnt;
    vol_done = 1'b1; vol_volume = 16'd9;
    push_cmd(2'b00, 16'd3, 16'd8);
    for (int i = 0; i < 10 && !add_start; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL iso_ignored: got %b want 0", rsp_valid); end
    add_done = 1'b1; add_success = 1'b1;
    wait_rsp(10, n);
    checks++; if ({rsp_valid, rsp_op, rsp_ok, rsp_timeout, rsp_data} !== {1'b1, 2'b00, 1'b1, 1'b0, 16'd0}) begin
      errors++; $display("FAIL iso_rsp: got %h want %h", {rsp_valid, rsp_op, rsp_ok, rsp_timeout, rsp_data}, {1'b1, 2'b00, 1'b1, 1'b0, 16'd0}); end
    accept_rsp();
    // add_done stays high: a stale level during ISSUE must not complete the next ADD
    push_cmd(2'b00, 16'd4, 16'd8);
    @(negedge clk); @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL stale_issue: got %b want 0", rsp_valid); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL stale_wait: got %b want 1", rsp_valid); end
    accept_rsp();
    add_done = 1'b0; vol_done = 1'b0;
    checks++; if ({add_cnt - a0, del_cnt - d0, vol_cnt - v0} !== {32'd2, 32'd0, 32'd0}) begin
      errors++; $display("FAIL iso_pulses: got %0d/%0d/%0d want 2/0/0", add_cnt - a0, del_cnt - d0, vol_cnt - v0); end
    a0 = add_cnt; d0 = del_cnt; v0 = vol_cnt;
    push_cmd(2'b11, 16'd9, 16'd9);
    @(negedge clk);
    checks++; if ({rsp_valid, rsp_op, rsp_ok, rsp_timeout, rsp_data} !== {1'b1, 2'b11, 1'b0, 1'b0, 16'd0}) begin
      errors++; $display("FAIL rsvd_rsp: got %h want %h", {rsp_valid, rsp_op, rsp_ok, rsp_timeout, rsp_data}, {1'b1, 2'b11, 1'b0, 1'b0, 16'd0}); end
    accept_rsp();
    checks++; if ({add_cnt - a0, del_cnt - d0, vol_cnt - v0} !== {32'd0, 32'd0, 32'd0}) begin
      errors++; $display("FAIL rsvd_pulses: got %0d/%0d/%0d want 0/0/0", add_cnt - a0, del_cnt - d0, vol_cnt - v0); end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  ops_in [6] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10};
    logic [1:0]  exp_op [5] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01};
    logic        exp_ok [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [15:0] exp_dat[5] = '{16'd0, 16'd0, 16'd7, 16'd0, 16'd0};
    logic [15:0] ids [8];
    logic [19:0] rsps[8];
    int acc = 0, ns = 0, nr = 0, extra = 0;
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1; cmd_op = ops_in[i]; cmd_id = 16'(10 + i);
      cmd_size = 16'd2; cmd_limit = 16'd3;
      if (cmd_ready) acc++;
      @(negedge clk);
      if ((add_start | del_start | vol_start) && ns < 8) begin ids[ns] = eng_id; ns++; end
    end
    cmd_valid = 1'b0;
    checks++; if (acc != 5) begin errors++; $display("FAIL bp_accepted: got %0d want 5", acc); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b want 0", cmd_ready); end
    add_done = 1'b1; del_done = 1'b1; vol_done = 1'b1;
    add_success = 1'b1; del_success = 1'b0; vol_volume = 16'd7; rsp_ready = 1'b1;
    for (int g = 0; g < 100 && nr < 5; g++) begin
      @(negedge clk);
      if ((add_start | del_start | vol_start) && ns < 8) begin ids[ns] = eng_id; ns++; end
      if (rsp_valid) begin rsps[nr] = {rsp_op, rsp_ok, rsp_timeout, rsp_data}; nr++; end
    end
    checks++; if (nr != 5) begin errors++; $display("FAIL bp_rsp_count: got %0d want 5", nr); end
    for (int i = 0; i < 5 && i < nr; i++) begin
      checks++;
      if (rsps[i] !== {exp_op[i], exp_ok[i], 1'b0, exp_dat[i]}) begin
        errors++; $display("FAIL bp_rsp%0d: got %h want %h", i, rsps[i], {exp_op[i], exp_ok[i], 1'b0, exp_dat[i]}); end
    end
    for (int i = 0; i < 5 && i < ns; i++) begin
      checks++;
      if (ids[i] !== 16'(10 + i)) begin errors++; $display("FAIL bp_order%0d: got %0d want %0d", i, ids[i], 10 + i); end
    end
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) extra++;
    end
    checks++; if ({extra, ns, busy} !== {32'd0, 32'd5, 1'b0}) begin
      errors++; $display("FAIL bp_tail: got extra=%0d starts=%0d busy=%b want 0/5/0", extra, ns, busy); end
    add_done = 1'b0; del_done = 1'b0; vol_done = 1'b0; rsp_ready = 1'b0; del_success = 1'b0;
  endtask

  task automatic test_reset_mid();
    int a0, d0, v0, seen = 0;
    push_cmd(2'b01, 16'd20, 16'd1);
    push_cmd(2'b00, 16'd21, 16'd1);
    push_cmd(2'b10, 16'd22, 16'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if ({cmd_ready, busy, rsp_valid, add_start, del_start, vol_start} !== 6'b100000) begin
      errors++; $display("FAIL rmid_ctrl: got %b want 100000", {cmd_ready, busy, rsp_valid, add_start, del_start, vol_start}); end
    checks++; if ({eng_side, eng_id, eng_size, eng_limit, rsp_op, rsp_ok, rsp_timeout, rsp_data} !== 69'd0) begin
      errors++; $display("FAIL rmid_regs: got %h want 0", {eng_side, eng_id, eng_size, eng_limit, rsp_op, rsp_ok, rsp_timeout, rsp_data}); end
    @(negedge clk);
    rst = 1'b0;
    a0 = add_cnt; d0 = del_cnt; v0 = vol_cnt;
    add_done = 1'b1; del_done = 1'b1; vol_done = 1'b1; rsp_ready = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid | busy) seen++;
    end
    checks++; if ({seen, add_cnt - a0, del_cnt - d0, vol_cnt - v0} !== 128'd0) begin
      errors++; $display("FAIL rmid_after: got rsp/busy=%0d starts=%0d/%0d/%0d want 0", seen, add_cnt - a0, del_cnt - d0, vol_cnt - v0); end
    add_done = 1'b0; del_done = 1'b0; vol_done = 1'b0; rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_volume();
    test_timeout();
    test_isolation();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
